vu_frame_sequencer: RTL
=======================

VU_FRAME_SEQUENCER -- requirements
Module: vu_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 20, meaning LEDs per frame (1..100).
REQ-002 SHALL have parameter BANK0_BASE, default 0, meaning ROM base address of the red pattern.
REQ-003 SHALL have parameter BANK1_BASE, default 100, meaning ROM base address of the blue pattern.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_start, input, 1 bit: one-cycle request to emit one frame.
REQ-007 SHALL have port i_level, input, 7 bits: number of lit LEDs, counted from index 0.
REQ-008 SHALL have port i_bank_sel, input, 1 bit: 0 selects BANK0_BASE, 1 selects BANK1_BASE.
REQ-009 SHALL have port o_rom_addr, output, 8 bits: ROM read address.
REQ-010 SHALL have port o_rom_ren, output, 1 bit: ROM read enable.
REQ-011 SHALL have port i_rom_data, input, 24 bits: ROM data, valid one cycle after the enabling edge.
REQ-012 SHALL have port o_pix_data, output, 24 bits: pixel colour.
REQ-013 SHALL have port o_pix_valid, output, 1 bit: o_pix_data is valid.
REQ-014 SHALL have port i_pix_ready, input, 1 bit: the serializer accepts the pixel.
REQ-015 SHALL have port o_busy, output, 1 bit: a frame is in progress.
REQ-016 SHALL have port o_done, output, 1 bit: one-cycle pulse after the last pixel is accepted.

Function
REQ-017 SHALL use the FSM states IDLE, FETCH, CAPTURE, PRESENT and DONE.
REQ-018 SHALL, in IDLE with i_start=1, latch min(i_level, NUM_LEDS) and i_bank_sel, clear the index to 0, and move to FETCH.
REQ-019 SHALL ignore i_start in every state other than IDLE, and SHALL NOT sample i_level or i_bank_sel mid-frame.
REQ-020 SHALL, in FETCH, drive o_rom_ren=1 and o_rom_addr=base+index for exactly one cycle when index < latched level, and then go to CAPTURE.
REQ-021 SHALL, in FETCH with index >= latched level, issue no ROM read and go to CAPTURE with a pending pixel of 24'h000000.
REQ-022 SHALL, in CAPTURE, register i_rom_data (or the zero pixel) into o_pix_data, assert o_pix_valid, and go to PRESENT.
REQ-023 SHALL sample i_rom_data only in CAPTURE, because the ROM output is undefined when ren=0.
REQ-024 SHALL, in PRESENT, hold o_pix_data and o_pix_valid stable until the cycle in which o_pix_valid and i_pix_ready are both 1.
REQ-025 SHALL, on a PRESENT handshake, drop o_pix_valid and either increment the index and go to FETCH, or go to DONE if the index equals NUM_LEDS-1.
REQ-026 SHALL, in DONE, pulse o_done for one cycle and return to IDLE.
REQ-027 SHALL hold o_busy=1 in every state except IDLE.
REQ-028 SHALL give a minimum of 3 cycles per pixel and a minimum frame time of 3*NUM_LEDS+1 cycles.
REQ-029 SHALL keep o_rom_addr at 0 whenever o_rom_ren=0.
REQ-030 SHALL output all pixels as zero when the latched level is 0, and all pixels from ROM when i_level >= NUM_LEDS.

Reset
REQ-031 SHALL, while i_rst=1, force the state to IDLE, clear the index and latched level, and set o_rom_ren, o_rom_addr, o_pix_data, o_pix_valid, o_busy and o_done to 0.
REQ-032 SHALL, on reset asserted mid-frame, abandon the frame immediately with no o_done pulse, and the next i_start SHALL begin a fresh frame at index 0.

Configuration
REQ-033 SHALL, with macro VU_PEAK_HOLD_EN defined, keep a peak register that is updated at each i_start to max(peak, clamped level) and decremented by 1 (floor 0) every 8th frame without a new maximum.
REQ-034 SHALL, with VU_PEAK_HOLD_EN defined, fetch from ROM the pixel at index peak-1 even when it is above the level, so that it lights as the peak marker.
REQ-035 SHALL, with VU_PEAK_HOLD_EN undefined, contain no peak logic and behave exactly per REQ-017..REQ-030.

Structure
REQ-036 SHALL place the state enum, the bank base constants and the zero-pixel constant in the shared package vu_pkg.
REQ-037 SHALL contain the peak tracker as the sub-module vu_peak_hold, instantiated only under VU_PEAK_HOLD_EN; everything else is flat.

Verification
REQ-038 SHALL check: i_start, level=5, bank=0, i_pix_ready=1 -> ROM reads at addresses 0..4 only; pixels 0..4=24'h000F00, pixels 5..19=0; o_done in cycle 61.
REQ-039 SHALL check: level=20, bank=1 -> ROM reads at 100..119; pixels 0..9=0, pixels 10..19=24'h00000F.
REQ-040 SHALL check: i_pix_ready held at 0 for 10 cycles on pixel 3 -> o_pix_data stable and no further ROM read until the handshake.
REQ-041 SHALL check: level=127 -> clamped to 20, all ROM reads issued, exactly 20 pixels output.
REQ-042 SHALL check: i_start pulsed while busy -> ignored; i_rst at pixel 7 -> outputs 0 next cycle, no o_done; next frame starts at address base+0.
REQ-043 SHALL check, under VU_PEAK_HOLD_EN: frames at level 10 then level 3 -> the second frame lights pixels 0..2 and 9.

Source files
------------

// File: rtl/vu_pkg.sv
// -----------------------------------------------------------------------------
// vu_pkg
// Constants and types shared by the VU meter frame sequencer:
//   - state_e    : sequencer FSM states
//   - VU_BANK*   : default ROM base addresses of the red and blue patterns
//   - ZERO_PIXEL : colour sent for unlit LEDs
//   - clamp_level: limits a requested level to the LED count
// -----------------------------------------------------------------------------
package vu_pkg;

   localparam int LEVEL_W = 7;
   localparam int ADDR_W  = 8;
   localparam int PIX_W   = 24;

   localparam int VU_BANK0_BASE = 0;
   localparam int VU_BANK1_BASE = 100;

   localparam logic [PIX_W-1:0] ZERO_PIXEL = 24'h000000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      PRESENT,
      DONE
   } state_e;

   function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] level,
                                                      input logic [LEVEL_W-1:0] max_level);
      return (level > max_level) ? max_level : level;
   endfunction

endpackage

// File: rtl/vu_peak_hold.sv
// -----------------------------------------------------------------------------
// vu_peak_hold
// Peak tracker for the VU meter (only used when VU_PEAK_HOLD_EN is defined).
// On every i_update the peak becomes max(peak, i_level); every 8th update that
// does not raise the peak decrements it by one, never below zero.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset, clears peak and age
//   i_update : one-cycle strobe, a new frame is starting
//   i_level  : clamped level of that frame
//   o_peak   : current peak (valid from the cycle after i_update)
// -----------------------------------------------------------------------------
module vu_peak_hold
   import vu_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_update,
   input  logic [LEVEL_W-1:0] i_level,
   output logic [LEVEL_W-1:0] o_peak
);

   logic [LEVEL_W-1:0] peak_q, peak_d;
   logic [2:0]         age_q, age_d;   // frames since the last new maximum, wraps every 8

   always_comb begin
      peak_d = peak_q;
      age_d  = age_q;
      if (i_update) begin
         if (i_level > peak_q) begin
            peak_d = i_level;
            age_d  = '0;
         end else begin
            age_d = age_q + 3'd1;
            if (age_q == 3'd7 && peak_q != '0) begin
               peak_d = peak_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         peak_q <= '0;
         age_q  <= '0;
      end else begin
         peak_q <= peak_d;
         age_q  <= age_d;
      end
   end

   assign o_peak = peak_q;

endmodule

// File: rtl/vu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// vu_frame_sequencer
// Emits one frame of NUM_LEDS pixels to an LED serializer. LEDs below the
// latched level are read from a synchronous ROM (red or blue bank), the rest
// are sent as ZERO_PIXEL. Each pixel takes FETCH -> CAPTURE -> PRESENT, so a
// frame is at least 3*NUM_LEDS+1 cycles including the DONE cycle.
// Optional feature: define VU_PEAK_HOLD_EN to add a decaying peak marker
// (the LED at index peak-1 is always fetched from ROM).
// Ports:
//   i_clk, i_rst      : clock and synchronous active-high reset
//   i_start           : one-cycle frame request, honoured only in IDLE
//   i_level           : lit LED count, clamped to NUM_LEDS
//   i_bank_sel        : 0 = BANK0_BASE, 1 = BANK1_BASE
//   o_rom_addr/ren    : ROM read port, data returns one cycle later
//   i_rom_data        : ROM read data
//   o_pix_data/valid  : pixel stream, held until i_pix_ready
//   i_pix_ready       : serializer accepts the pixel
//   o_busy            : frame in progress
//   o_done            : one-cycle pulse after the last pixel is accepted
// -----------------------------------------------------------------------------
module vu_frame_sequencer
   import vu_pkg::*;
#(
   parameter int NUM_LEDS   = 20,
   parameter int BANK0_BASE = VU_BANK0_BASE,
   parameter int BANK1_BASE = VU_BANK1_BASE
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [LEVEL_W-1:0] i_level,
   input  logic               i_bank_sel,
   output logic [ADDR_W-1:0]  o_rom_addr,
   output logic               o_rom_ren,
   input  logic [PIX_W-1:0]   i_rom_data,
   output logic [PIX_W-1:0]   o_pix_data,
   output logic               o_pix_valid,
   input  logic               i_pix_ready,
   output logic               o_busy,
   output logic               o_done
);

   localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_LEDS);
   localparam logic [LEVEL_W-1:0] LAST_IDX  = LEVEL_W'(NUM_LEDS - 1);
   localparam logic [ADDR_W-1:0]  BASE0     = ADDR_W'(BANK0_BASE);
   localparam logic [ADDR_W-1:0]  BASE1     = ADDR_W'(BANK1_BASE);

   state_e             state_q, state_d;
   logic [LEVEL_W-1:0] index_q, index_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               bank_q, bank_d;
   logic [PIX_W-1:0]   pix_data_q, pix_data_d;
   logic               pix_valid_q, pix_valid_d;

   logic [LEVEL_W-1:0] start_level;
   logic [ADDR_W-1:0]  base_addr;
   logic               fetch_en;
   logic               rom_ren;
   logic [ADDR_W-1:0]  rom_addr;

   assign start_level = clamp_level(i_level, MAX_LEVEL);
   assign base_addr   = bank_q ? BASE1 : BASE0;

`ifdef VU_PEAK_HOLD_EN
   logic [LEVEL_W-1:0] peak;

   vu_peak_hold u_peak_hold (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_update (state_q == IDLE && i_start),
      .i_level  (start_level),
      .o_peak   (peak)
   );

   // The peak marker LED is fetched even when it sits above the current level.
   assign fetch_en = (index_q < level_q) || (peak != '0 && index_q == peak - 1'b1);
`else
   assign fetch_en = (index_q < level_q);
`endif

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      level_d     = level_q;
      bank_d      = bank_q;
      pix_data_d  = pix_data_q;
      pix_valid_d = pix_valid_q;
      rom_ren     = 1'b0;
      rom_addr    = '0;

      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               level_d = start_level;
               bank_d  = i_bank_sel;
               index_d = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (fetch_en) begin
               rom_ren  = 1'b1;
               rom_addr = base_addr + ADDR_W'(index_q);
            end
            state_d = CAPTURE;
         end
         CAPTURE: begin
            // ROM data is undefined unless a read was issued in FETCH.
            pix_data_d  = fetch_en ? i_rom_data : ZERO_PIXEL;
            pix_valid_d = 1'b1;
            state_d     = PRESENT;
         end
         PRESENT: begin
            if (pix_valid_q && i_pix_ready) begin
               pix_valid_d = 1'b0;
               if (index_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         index_q     <= '0;
         level_q     <= '0;
         bank_q      <= 1'b0;
         pix_data_q  <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         level_q     <= level_d;
         bank_q      <= bank_d;
         pix_data_q  <= pix_data_d;
         pix_valid_q <= pix_valid_d;
      end
   end

   // State-decoded outputs are also forced low while reset is held.
   assign o_rom_ren   = rom_ren & ~i_rst;
   assign o_rom_addr  = i_rst ? '0 : rom_addr;
   assign o_busy      = (state_q != IDLE) & ~i_rst;
   assign o_done      = (state_q == DONE) & ~i_rst;
   assign o_pix_data  = pix_data_q;
   assign o_pix_valid = pix_valid_q;

endmodule
